// File: rtl/sum_nb_seq.sv
// sum_nb_seq: multi-cycle WIDTH-bit adder/subtractor for the ALU.
// A CHUNK-bit ripple slice is reused for WIDTH/CHUNK cycles, working from the
// least significant chunk upwards. The result and flags are registered and
// held until the next completion or reset.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             request an operation (accepted only while ready)
//   Sub               0: add, 1: subtract (sampled with start)
//   A, B, Ci          operands and carry/borrow-in (sampled with start)
//   ready, busy, done IDLE / RUN / one-cycle completion indicators
//   Sum, Cout, Ovf, Zero  registered result and flags

// One-bit full adder, the per-bit cell of the ripple slice.
module sum_nb_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// CHUNK-bit ripple slice. Also exposes the carry into its top bit so the
// top-level can form the signed overflow flag on the last chunk.
module sum_nb_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);
    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        sum_nb_fa u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];
endmodule

module sum_nb_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg, res_reg, res_nxt;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic [31:0]      sh;
    logic [CHUNK-1:0] sl_a, sl_b, sl_s;
    logic             sl_co, sl_cmsb;

    assign last = (cnt == CNT_W'(NCHUNK - 1));
    assign sh   = 32'(cnt) * 32'(CHUNK);

    // Select the current chunk; b_reg already holds ~B for subtraction.
    assign sl_a = CHUNK'(a_reg >> sh);
    assign sl_b = CHUNK'(b_reg >> sh);

    sum_nb_slice #(.CHUNK(CHUNK)) u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .ci    (carry),
        .s     (sl_s),
        .co    (sl_co),
        .c_msb (sl_cmsb)
    );

    // Merge the freshly computed chunk into the partial result.
    assign res_nxt = (res_reg & ~(CHUNK_MASK << sh)) | (WIDTH'(sl_s) << sh);

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            Sum     <= '0;
            Cout    <= 1'b0;
            Ovf     <= 1'b0;
            Zero    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg <= A;
                        b_reg <= Sub ? ~B : B;
                        // Subtraction is A + ~B + ~Ci, so the borrow-in inverts.
                        carry <= Ci ^ Sub;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    res_reg <= res_nxt;
                    carry   <= sl_co;
                    cnt     <= cnt + CNT_W'(1);
                    if (last) begin
                        Sum  <= res_nxt;
                        Cout <= sl_co;
                        Ovf  <= sl_cmsb ^ sl_co;
                        Zero <= (res_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sum_nb_seq.sv
module tb_sum_nb_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, sub, ci;
    logic [15:0] a, b;
    logic        ready, busy, done, cout, ovf, zero;
    logic [15:0] sum;

    int n_checks = 0;
    int n_errors = 0;
    int n_edges, n_busy, n_done, n_rdy_bad;

    always #5 clk = ~clk;

    sum_nb_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .Sub(sub), .A(a), .B(b), .Ci(ci),
        .ready(ready), .busy(busy), .done(done), .Sum(sum), .Cout(cout),
        .Ovf(ovf), .Zero(zero)
    );

    // Parameter sweep instances: 0:(8,8) 1:(8,1) 2:(32,4), shared stimulus.
    logic        sw_start, sw_sub, sw_ci;
    logic [31:0] sw_a, sw_b;
    logic [2:0]  sw_ready, sw_busy, sw_done, sw_cout, sw_ovf, sw_zero;
    logic [7:0]  s0, s1;
    logic [31:0] s2;
    logic [31:0] sw_sum [3];

    assign sw_sum[0] = {24'b0, s0};
    assign sw_sum[1] = {24'b0, s1};
    assign sw_sum[2] = s2;

    sum_nb_seq #(.WIDTH(8), .CHUNK(8)) dut_8_8 (
        .clk(clk), .rst(rst), .start(sw_start), .Sub(sw_sub), .A(sw_a[7:0]), .B(sw_b[7:0]),
        .Ci(sw_ci), .ready(sw_ready[0]), .busy(sw_busy[0]), .done(sw_done[0]), .Sum(s0),
        .Cout(sw_cout[0]), .Ovf(sw_ovf[0]), .Zero(sw_zero[0])
    );
    sum_nb_seq #(.WIDTH(8), .CHUNK(1)) dut_8_1 (
        .clk(clk), .rst(rst), .start(sw_start), .Sub(sw_sub), .A(sw_a[7:0]), .B(sw_b[7:0]),
        .Ci(sw_ci), .ready(sw_ready[1]), .busy(sw_busy[1]), .done(sw_done[1]), .Sum(s1),
        .Cout(sw_cout[1]), .Ovf(sw_ovf[1]), .Zero(sw_zero[1])
    );
    sum_nb_seq #(.WIDTH(32), .CHUNK(4)) dut_32_4 (
        .clk(clk), .rst(rst), .start(sw_start), .Sub(sw_sub), .A(sw_a), .B(sw_b),
        .Ci(sw_ci), .ready(sw_ready[2]), .busy(sw_busy[2]), .done(sw_done[2]), .Sum(s2),
        .Cout(sw_cout[2]), .Ovf(sw_ovf[2]), .Zero(sw_zero[2])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op on the 16/4 instance and wait (bounded) for done.
    // n_edges counts edges after the start edge until done is seen.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic ts, input logic tc);
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; ci = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; sub = ~ts; ci = ~tc;
        n_edges = 0; n_busy = 0;
        while (!done && n_edges < 20) begin
            if (busy) n_busy++;
            @(negedge clk);
            n_edges++;
        end
        chk("done_seen", {63'b0, done}, 64'd1);
    endtask

    initial begin
        logic [63:0] mask, ma, mb, bb, full, exp_sum;
        logic        exp_c, exp_v;
        int          w [3];
        int          nch [3];
        int          lat [3];
        logic [31:0] g_sum [3];
        logic [2:0]  g_flg [3];
        logic [2:0]  seen;

        w   = '{8, 8, 32};
        nch = '{1, 8, 8};

        rst = 1'b1; start = 1'b0; sub = 1'b0; ci = 1'b0; a = '0; b = '0;
        sw_start = 1'b0; sw_sub = 1'b0; sw_ci = 1'b0; sw_a = '0; sw_b = '0;
        #1;
        chk("rst_sum",   {48'b0, sum}, 64'h0);
        chk("rst_flags", {60'b0, cout, ovf, zero, done}, 64'h0);
        chk("rst_ready", {62'b0, ready, busy}, 64'b10);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: basic add, latency and busy duration
        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0);
        chk("t1_lat",  n_edges, 4);
        chk("t1_busy", n_busy, 4);
        chk("t1_sum",  {48'b0, sum}, 64'h2233);
        chk("t1_flags", {61'b0, cout, ovf, zero}, 64'b000);

        // 2: carry/zero, signed overflow
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        chk("t2a_sum", {48'b0, sum}, 64'h0000);
        chk("t2a_flags", {61'b0, cout, ovf, zero}, 64'b101);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        chk("t2b_sum", {48'b0, sum}, 64'h8000);
        chk("t2b_flags", {61'b0, cout, ovf, zero}, 64'b010);

        // 3: subtract
        run_op(16'h0005, 16'h0007, 1'b1, 1'b0);
        chk("t3a_sum", {48'b0, sum}, 64'hFFFE);
        chk("t3a_flags", {61'b0, cout, ovf, zero}, 64'b000);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0);
        chk("t3b_sum", {48'b0, sum}, 64'h7FFF);
        chk("t3b_flags", {61'b0, cout, ovf, zero}, 64'b110);
        run_op(16'h0010, 16'h0003, 1'b1, 1'b1);
        chk("t3c_sum", {48'b0, sum}, 64'h000C);
        chk("t3c_flags", {61'b0, cout, ovf, zero}, 64'b100);

        // 4: start during RUN is ignored
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; sub = 1'b0; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_done = 0; n_rdy_bad = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) n_done++;
            if ((busy || done) && ready) n_rdy_bad++;
            if (k == 1) begin a = 16'h00F0; b = 16'h0F00; start = 1'b1; end
            else start = 1'b0;
            @(negedge clk);
        end
        chk("t4_done_cnt", n_done, 1);
        chk("t4_ready",    n_rdy_bad, 0);
        chk("t4_sum",      {48'b0, sum}, 64'h0002);

        // 5: asynchronous reset in RUN cycle 2
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_sum",   {48'b0, sum}, 64'h0);
        chk("t5_state", {61'b0, ready, busy, done}, 64'b100);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int k = 0; k < 8; k++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        chk("t5_no_done", n_done, 0);
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
        chk("t5_lat", n_edges, 4);
        chk("t5_sum2", {48'b0, sum}, 64'h0100);

        // 6: parameter sweep against a reference model
        for (int op = 0; op < 1000; op++) begin
            @(negedge clk);
            sw_a = $urandom; sw_b = $urandom;
            sw_sub = 1'($urandom_range(0, 1)); sw_ci = 1'($urandom_range(0, 1));
            sw_start = 1'b1;
            seen = '0;
            for (int i = 0; i < 3; i++) lat[i] = 99;
            @(negedge clk);
            sw_start = 1'b0;
            for (int k = 0; k < 12; k++) begin
                for (int i = 0; i < 3; i++) begin
                    if (sw_done[i] && !seen[i]) begin
                        seen[i]  = 1'b1;
                        lat[i]   = k;
                        g_sum[i] = sw_sum[i];
                        g_flg[i] = {sw_cout[i], sw_ovf[i], sw_zero[i]};
                    end
                end
                @(negedge clk);
            end
            for (int i = 0; i < 3; i++) begin
                mask = (64'd1 << w[i]) - 64'd1;
                ma   = {32'b0, sw_a} & mask;
                mb   = {32'b0, sw_b} & mask;
                bb   = sw_sub ? (~mb & mask) : mb;
                full = ma + bb + {63'b0, sw_ci ^ sw_sub};
                exp_sum = full & mask;
                exp_c   = full[w[i]];
                exp_v   = (ma[w[i]-1] == bb[w[i]-1]) && (exp_sum[w[i]-1] != ma[w[i]-1]);
                chk($sformatf("sw%0d_lat", i), lat[i], nch[i]);
                chk($sformatf("sw%0d_sum", i), {32'b0, g_sum[i]}, exp_sum);
                chk($sformatf("sw%0d_flags", i), {61'b0, g_flg[i]},
                    {61'b0, exp_c, exp_v, exp_sum == 64'd0});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sum_nb_seq.md
Name: sum_nb_seq

Overview:
Parametrised multi-cycle adder/subtractor for the ALU. It replaces the fixed 4-bit ripple adder with a WIDTH-bit datapath built from a CHUNK-bit ripple slice, which the block reuses over WIDTH/CHUNK cycles. It has a start/done handshake, an add/subtract mode, and carry, signed-overflow and zero flags. The ALU control unit sequences it; results stay registered until the next operation.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK
CHUNK, 4, bits processed per cycle by the internal ripple slice; 1 <= CHUNK <= WIDTH
(derived) NCHUNK = WIDTH/CHUNK, number of processing cycles

Ports:
clk    input   1       clock; all state changes on the rising edge
rst    input   1       reset; asynchronous, active-high
start  input   1       request an operation; sampled only in IDLE
Sub    input   1       0: add, 1: subtract; sampled with start
A      input   WIDTH   operand A; sampled with start
B      input   WIDTH   operand B; sampled with start
Ci     input   1       carry-in (add) or borrow-in (sub); sampled with start
ready  output  1       high in IDLE; start is accepted only when ready=1
busy   output  1       high in RUN
done   output  1       one-cycle pulse when the result is valid
Sum    output  WIDTH   result register
Cout   output  1       carry-out of the MSB (sub: 1 = no borrow)
Ovf    output  1       signed overflow
Zero   output  1       Sum == 0

Behaviour:
- Reset: clk and rst are the only clocking/reset ports; one clock, reset is asynchronous and active-high.
  - Assertion takes effect immediately, independent of clk.
  - State goes to IDLE and the chunk counter to 0.
  - Sum=0, Cout=0, Ovf=0, Zero=0, done=0, busy=0, ready=1.
  - Reset during RUN or DONE aborts the operation; no done pulse is produced.
- Arithmetic:
  - Add: {Cout,Sum} = A + B + Ci.
  - Sub: {Cout,Sum} = A + ~B + ~Ci, i.e. A - B - Ci.
  - Ovf = carry into MSB XOR carry out of MSB.
  - All arithmetic is modulo 2^WIDTH.
- Start edge (IDLE with start=1):
  - Latch A and latch B (or ~B when Sub=1).
  - Carry register = Ci XOR Sub.
  - Counter = 0; go to RUN.
- RUN, one chunk per edge:
  - Chunk k (bits k*CHUNK .. k*CHUNK+CHUNK-1) is added with the carry register, using a ripple of 1-bit full adders.
  - The chunk sum goes to an internal result register; the carry register takes the chunk carry-out.
  - The counter increments after each chunk.
  - On the last chunk (k = NCHUNK-1), capture the carry into the MSB for Ovf, then go to DONE.
- Output timing:
  - Sum, Cout, Ovf and Zero update only on the edge that enters DONE. done rises on that same edge.
  - Latency: done is high in the cycle after the NCHUNK-th edge following the start edge.
- DONE lasts exactly one cycle (done=1), then the block returns to IDLE.
  - Outputs hold their values until the next completion or reset.
- start while RUN or DONE is ignored and does not corrupt the operation in flight.
- A, B, Sub and Ci may change freely after the start edge.
- CHUNK=WIDTH degenerates to 1 RUN cycle. Throughput is one operation per NCHUNK+2 cycles.

Test Plan:
1. WIDTH=16, CHUNK=4: A=0x1234, B=0x0FFF, Sub=0, Ci=0, start pulse -> done exactly 4 edges after the start edge; Sum=0x2233, Cout=0, Ovf=0, Zero=0; busy high for 4 cycles.
2. Add carry and zero: A=0xFFFF, B=0x0001, Ci=0 -> Sum=0x0000, Cout=1, Zero=1, Ovf=0. Signed overflow: A=0x7FFF, B=0x0001 -> Sum=0x8000, Ovf=1, Cout=0.
3. Subtract: A=0x0005, B=0x0007, Sub=1, Ci=0 -> Sum=0xFFFE, Cout=0 (borrow). A=0x8000, B=0x0001 -> Sum=0x7FFF, Ovf=1, Cout=1. A=0x0010, B=0x0003, Ci=1 -> Sum=0x000C.
4. Protocol: start with A=0x0001, B=0x0001; change A/B and pulse start again 2 cycles later -> the second start is ignored, Sum=0x0002, exactly one done pulse; ready=0 during RUN/DONE.
5. Reset mid-op: assert rst asynchronously in RUN cycle 2 -> outputs cleared immediately, no done pulse; the next start completes normally with a correct result.
6. Parameter sweep: (WIDTH,CHUNK) = (8,8), (8,1), (32,4); random operands and modes, 1000 ops each, checked against a reference model -> all results match; latency = NCHUNK edges.
